ps_ddr_rd_sched: RTL and testbench

//  Upstream job sequencer for the PS-DDR3 MM2S read stage. Accepts one read job (byte address + byte length).

---
 rtl/ps_ddr_pkg.sv | 28 ++
 rtl/ps_ddr_rd_sched.sv | 209 ++++++++++++++++++++
 tb/tb_ps_ddr_rd_sched.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_ddr_pkg.sv
// ----------------------------------------------------------------------------
// ps_ddr_pkg
//   Shared definitions for the PS-DDR3 MM2S read job sequencer.
//   - rd_state_e     : sequencer state encoding
//   - BYTES_PER_BEAT : bytes carried by one ps_ddr_rd_en beat
//   - BTT_W          : width of the DataMover bytes-to-transfer field
//   - chunk_len()    : size of the next chunk for a given remaining count
// ----------------------------------------------------------------------------
package ps_ddr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } rd_state_e;

  localparam int BYTES_PER_BEAT = 4;
  localparam int BTT_W          = 23;

  // Next chunk is whatever is left, capped at the largest BTT-safe size.
  function automatic logic [31:0] chunk_len(input logic [31:0] remaining,
                                            input logic [31:0] max_chunk);
    return (remaining < max_chunk) ? remaining : max_chunk;
  endfunction

endpackage

// File: rtl/ps_ddr_rd_sched.sv
// ----------------------------------------------------------------------------
// ps_ddr_rd_sched
//   Upstream job sequencer for the PS-DDR3 MM2S read stage. One read job
//   (byte address + byte length) is split into chunks of at most MAX_CHUNK
//   bytes. For each chunk the address/length are presented, a start level is
//   held for START_HOLD cycles, and the returned beats are counted. A job ends
//   with a single job_done pulse, or a job_err pulse on a misaligned request
//   or when no beat arrives for TIMEOUT cycles while waiting.
//
// Ports
//   clk_ps           in   PS fabric clock
//   rst_n            in   asynchronous reset, active low
//   job_start        in   1-cycle job request, sampled only when idle
//   job_addr         in   [31:0] job byte address (4-byte aligned)
//   job_length       in   [31:0] job byte count (multiple of 4)
//   job_busy         out  high from job acceptance until done/err
//   job_done         out  1-cycle pulse, all beats of all chunks received
//   job_err          out  1-cycle pulse, misaligned request or timeout
//   ps_ddr_rd_start  out  chunk start level (edge-detected by the read stage)
//   ps_ddr_rd_addr   out  [31:0] current chunk byte address
//   ps_ddr_rd_length out  [31:0] current chunk byte count ([31:23] always 0)
//   ps_ddr_rd_en     in   one 32-bit beat returned by the read stage
// ----------------------------------------------------------------------------
module ps_ddr_rd_sched
  import ps_ddr_pkg::*;
#(
  parameter logic [31:0] MAX_CHUNK  = 32'h0040_0000,
  parameter int          START_HOLD = 4,
  parameter int          GAP_CYCLES = 4,
  parameter int          TIMEOUT    = 1000000
) (
  input  logic        clk_ps,
  input  logic        rst_n,
  input  logic        job_start,
  input  logic [31:0] job_addr,
  input  logic [31:0] job_length,
  output logic        job_busy,
  output logic        job_done,
  output logic        job_err,
  output logic        ps_ddr_rd_start,
  output logic [31:0] ps_ddr_rd_addr,
  output logic [31:0] ps_ddr_rd_length,
  input  logic        ps_ddr_rd_en
);

  localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
  // A chunk is below 2^BTT_W bytes, so its beat count fits with one bit spare.
  localparam int BEAT_W     = BTT_W - BEAT_SHIFT + 1;
  localparam int TO_W       = $clog2(TIMEOUT + 1);
  localparam int PH_MAX     = (START_HOLD > GAP_CYCLES) ? START_HOLD : GAP_CYCLES;
  localparam int PH_W       = $clog2(PH_MAX + 1);

  rd_state_e         state_reg,     state_next;
  logic [31:0]       cur_addr_reg,  cur_addr_next;
  logic [31:0]       remaining_reg, remaining_next;
  logic [31:0]       rd_addr_reg,   rd_addr_next;
  logic [31:0]       rd_length_reg, rd_length_next;
  logic [BEAT_W-1:0] exp_beats_reg, exp_beats_next;
  logic [BEAT_W-1:0] beat_cnt_reg,  beat_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg,    to_cnt_next;
  logic [PH_W-1:0]   phase_reg,     phase_next;
  logic              start_reg,     start_next;
  logic              done_reg,      done_next;
  logic              err_reg,       err_next;

  logic [31:0]       setup_len;
  logic              job_misaligned;

  assign setup_len      = chunk_len(remaining_reg, MAX_CHUNK);
  assign job_misaligned = (job_addr[BEAT_SHIFT-1:0] != '0) ||
                          (job_length[BEAT_SHIFT-1:0] != '0);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      rd_addr_reg   <= '0;
      rd_length_reg <= '0;
      exp_beats_reg <= '0;
      beat_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      phase_reg     <= '0;
      start_reg     <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      rd_addr_reg   <= rd_addr_next;
      rd_length_reg <= rd_length_next;
      exp_beats_reg <= exp_beats_next;
      beat_cnt_reg  <= beat_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      phase_reg     <= phase_next;
      start_reg     <= start_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    rd_addr_next   = rd_addr_reg;
    rd_length_next = rd_length_reg;
    exp_beats_next = exp_beats_reg;
    beat_cnt_next  = beat_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    phase_next     = phase_reg;
    start_next     = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (job_start) begin
          if (job_misaligned) begin
            err_next = 1'b1;
          end else if (job_length == '0) begin
            done_next = 1'b1;
          end else begin
            cur_addr_next  = job_addr;
            remaining_next = job_length;
            state_next     = SETUP;
          end
        end
      end

      SETUP: begin
        rd_addr_next   = cur_addr_reg;
        rd_length_next = setup_len;
        exp_beats_next = BEAT_W'(setup_len >> BEAT_SHIFT);
        beat_cnt_next  = '0;
        to_cnt_next    = '0;
        phase_next     = '0;
        start_next     = 1'b1;
        state_next     = PULSE;
      end

      PULSE: begin
        // The read stage may answer before the start level drops; those beats
        // count, but never beyond the chunk's own beat total.
        if (ps_ddr_rd_en && (beat_cnt_reg != exp_beats_reg)) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
        if (phase_reg == PH_W'(START_HOLD - 1)) begin
          phase_next = '0;
          state_next = WAIT;
        end else begin
          phase_next = phase_reg + 1'b1;
          start_next = 1'b1;
        end
      end

      WAIT: begin
        if (beat_cnt_reg == exp_beats_reg) begin
          cur_addr_next  = cur_addr_reg + rd_length_reg;
          remaining_next = remaining_reg - rd_length_reg;
          phase_next     = '0;
          state_next     = GAP;
        end else if (ps_ddr_rd_en) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          to_cnt_next   = '0;
        end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th consecutive cycle without a beat.
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      GAP: begin
        if (phase_reg == PH_W'(GAP_CYCLES - 1)) begin
          phase_next = '0;
          if (remaining_reg != '0) begin
            state_next = SETUP;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign job_busy         = (state_reg != IDLE);
  assign job_done         = done_reg;
  assign job_err          = err_reg;
  assign ps_ddr_rd_start  = start_reg;
  assign ps_ddr_rd_addr   = rd_addr_reg;
  assign ps_ddr_rd_length = rd_length_reg;

endmodule

// File: tb/tb_ps_ddr_rd_sched.sv
module tb_ps_ddr_rd_sched;

  localparam logic [31:0] MAXC = 32'h0000_0100;
  localparam int          SH   = 4;
  localparam int          GC   = 4;
  localparam int          TO   = 100;

  logic        clk_ps = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_start = 1'b0;
  logic [31:0] job_addr = '0;
  logic [31:0] job_length = '0;
  logic        job_busy, job_done, job_err;
  logic        ps_ddr_rd_start;
  logic [31:0] ps_ddr_rd_addr, ps_ddr_rd_length;
  logic        ps_ddr_rd_en = 1'b0;

  ps_ddr_rd_sched #(
    .MAX_CHUNK (MAXC),
    .START_HOLD(SH),
    .GAP_CYCLES(GC),
    .TIMEOUT   (TO)
  ) dut (
    .clk_ps          (clk_ps),
    .rst_n           (rst_n),
    .job_start       (job_start),
    .job_addr        (job_addr),
    .job_length      (job_length),
    .job_busy        (job_busy),
    .job_done        (job_done),
    .job_err         (job_err),
    .ps_ddr_rd_start (ps_ddr_rd_start),
    .ps_ddr_rd_addr  (ps_ddr_rd_addr),
    .ps_ddr_rd_length(ps_ddr_rd_length),
    .ps_ddr_rd_en    (ps_ddr_rd_en)
  );

  always #5 clk_ps = ~clk_ps;

  int cyc = 0;
  always @(posedge clk_ps) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
  } chunk_t;

  chunk_t exp_chunks[$];
  int     exp_res[$];          // 1 = done, 2 = err
  int     res_cnt = 0;
  int     res_cyc = 0;
  int     beat_cap = 32'h7fff_ffff;
  int     last_beat_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: what a job must produce, from plain arithmetic.
  task automatic expect_job(input logic [31:0] addr, input logic [31:0] len, input bit timeout_mode);
    logic [31:0] a, r, c;
    chunk_t ch;
    if (addr[1:0] != 2'b00 || len[1:0] != 2'b00) begin
      exp_res.push_back(2);
    end else if (len == 32'd0) begin
      exp_res.push_back(1);
    end else begin
      a = addr;
      r = len;
      while (r != 32'd0) begin
        c = (r < MAXC) ? r : MAXC;
        ch.addr = a;
        ch.len  = c;
        exp_chunks.push_back(ch);
        a = a + c;
        r = r - c;
        if (timeout_mode) break;
      end
      exp_res.push_back(timeout_mode ? 2 : 1);
    end
  endtask

  // Read-stage responder: returns the chunk's beats at a random rate, starting
  // as soon as the start level rises; random noise on rd_en while idle.
  initial begin
    int  beats_left;
    bit  resp_prev;
    beats_left = 0;
    resp_prev  = 1'b0;
    forever begin
      @(negedge clk_ps);
      if (!rst_n) begin
        beats_left   = 0;
        resp_prev    = 1'b0;
        ps_ddr_rd_en = 1'b0;
        continue;
      end
      if (ps_ddr_rd_start && !resp_prev) begin
        beats_left = int'(ps_ddr_rd_length >> 2);
        if (beats_left > beat_cap) beats_left = beat_cap;
      end
      resp_prev = ps_ddr_rd_start;
      if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
        ps_ddr_rd_en  = 1'b1;
        beats_left--;
        last_beat_cyc = cyc;
      end else if (!job_busy && beats_left == 0 && $urandom_range(0, 3) == 0) begin
        ps_ddr_rd_en = 1'b1;
      end else begin
        ps_ddr_rd_en = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a chunk or a result.
  initial begin
    bit          m_prev_start, m_prev_de;
    int          m_high, m_low, m_chunks;
    logic [31:0] m_addr, m_len;
    chunk_t      c;
    int          e;
    m_prev_start = 1'b0; m_prev_de = 1'b0;
    m_high = 0; m_low = 0; m_chunks = 0;
    m_addr = '0; m_len = '0;
    forever begin
      @(negedge clk_ps);
      if (!rst_n) begin
        m_prev_start = 1'b0; m_prev_de = 1'b0;
        m_high = 0; m_low = 0; m_chunks = 0;
        continue;
      end
      if (ps_ddr_rd_start && !m_prev_start) begin
        if (exp_chunks.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_chunk: got addr 0x%08h len 0x%08h, expected no chunk", ps_ddr_rd_addr, ps_ddr_rd_length);
        end else begin
          c = exp_chunks.pop_front();
          check("chunk_addr", ps_ddr_rd_addr, c.addr);
          check("chunk_len", ps_ddr_rd_length, c.len);
          check("len_hi_zero", {23'd0, ps_ddr_rd_length[31:23]}, 32'd0);
          if (m_chunks > 0) check_range("gap_low_cycles", m_low, GC, 1000000);
        end
        $display("[TB] chunk addr=0x%08h len=0x%08h", ps_ddr_rd_addr, ps_ddr_rd_length);
        m_addr = ps_ddr_rd_addr;
        m_len  = ps_ddr_rd_length;
        m_high = 1;
        m_chunks++;
      end else if (ps_ddr_rd_start) begin
        m_high++;
      end
      if (!ps_ddr_rd_start && m_prev_start) begin
        check("start_hold", m_high, SH);
        check("addr_stable", ps_ddr_rd_addr, m_addr);
        check("len_stable", ps_ddr_rd_length, m_len);
        m_low = 1;
      end else if (!ps_ddr_rd_start) begin
        m_low++;
      end
      if (job_done || job_err) begin
        check("done_err_excl", {31'd0, job_done & job_err}, 32'd0);
        check("busy_at_end", {31'd0, job_busy}, 32'd0);
        check("pulse_width", {31'd0, m_prev_de}, 32'd0);
        if (exp_res.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got done=%0b err=%0b, expected none", job_done, job_err);
        end else begin
          e = exp_res.pop_front();
          check("result_kind", job_done ? 32'd1 : 32'd2, e);
        end
        $display("[TB] result done=%0b err=%0b at cycle %0d", job_done, job_err, cyc);
        res_cnt++;
        res_cyc  = cyc;
        m_chunks = 0;
      end
      m_prev_de    = job_done | job_err;
      m_prev_start = ps_ddr_rd_start;
    end
  end

  task automatic run_job(input logic [31:0] addr, input logic [31:0] len,
                         input bit timeout_mode, input bit poke_mid);
    int n0, c0, k;
    bit immediate;
    n0 = res_cnt;
    immediate = (addr[1:0] != 2'b00) || (len[1:0] != 2'b00) || (len == 32'd0);
    expect_job(addr, len, timeout_mode);
    beat_cap = timeout_mode ? 10 : 32'h7fff_ffff;
    @(negedge clk_ps);
    job_addr = addr; job_length = len; job_start = 1'b1;
    c0 = cyc;
    @(negedge clk_ps);
    job_start = 1'b0; job_addr = $urandom; job_length = $urandom;
    if (poke_mid) begin
      k = $urandom_range(5, 30);
      repeat (k) @(negedge clk_ps);
      if (job_busy) begin
        job_addr = 32'h5000_0000; job_length = 32'h40; job_start = 1'b1;
        @(negedge clk_ps);
        job_start = 1'b0;
      end
    end
    for (int i = 0; i < 40000 && res_cnt == n0; i++) @(negedge clk_ps);
    @(negedge clk_ps);
    if (res_cnt == n0) begin
      tests++; fails++;
      $display("FAIL job_timeout: got no result after 40000 cycles, expected done or err");
    end else begin
      check("results_per_job", res_cnt - n0, 1);
      if (immediate) check("immediate_latency", res_cyc - c0, 1);
      if (timeout_mode) check_range("timeout_cycles", res_cyc - last_beat_cyc, TO, TO + SH + 2);
    end
    check("chunks_left", exp_chunks.size(), 0);
    $display("[TB] job addr=0x%08h len=0x%08h timeout=%0b results=%0d", addr, len, timeout_mode, res_cnt - n0);
    beat_cap = 32'h7fff_ffff;
    repeat ($urandom_range(1, 4)) @(negedge clk_ps);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, job_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, job_done}, 32'd0);
    check({tag, "_err"},   {31'd0, job_err}, 32'd0);
    check({tag, "_start"}, {31'd0, ps_ddr_rd_start}, 32'd0);
    check({tag, "_addr"},  ps_ddr_rd_addr, 32'd0);
    check({tag, "_len"},   ps_ddr_rd_length, 32'd0);
  endtask

  task automatic reset_mid_job();
    bit saw;
    saw = 1'b0;
    expect_job(32'h4000_0000, 32'h200, 1'b0);
    @(negedge clk_ps);
    job_addr = 32'h4000_0000; job_length = 32'h200; job_start = 1'b1;
    @(negedge clk_ps);
    job_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_ps);
      if (ps_ddr_rd_start) saw = 1'b1;
      else if (saw) break;
    end
    check("reached_wait", {31'd0, saw}, 32'd1);
    repeat (3) @(negedge clk_ps);
    check("busy_before_rst", {31'd0, job_busy}, 32'd1);
    @(posedge clk_ps);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    $display("[TB] reset asserted mid-job");
    exp_chunks.delete();
    exp_res.delete();
    repeat (3) @(negedge clk_ps);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_ps);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, l;
    int r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_ps);
    check_all_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_ps);
    check_all_zero("post_rst");

    run_job(32'h1000_0000, 32'h100, 1'b0, 1'b0);    // single chunk
    run_job(32'h2000_0000, 32'h280, 1'b0, 1'b0);    // three chunks, short tail
    run_job(32'h2100_0000, 32'h200, 1'b0, 1'b0);    // exact multiple of max chunk
    run_job(32'h2200_0000, 32'h4,   1'b0, 1'b0);    // single beat
    run_job(32'h2300_0000, 32'h0,   1'b0, 1'b0);    // zero length
    run_job(32'h2300_0002, 32'h40,  1'b0, 1'b0);    // misaligned address
    run_job(32'h2300_0000, 32'h102, 1'b0, 1'b0);    // misaligned length
    run_job(32'h2400_0000, 32'h100, 1'b1, 1'b0);    // timeout after 10 beats
    run_job(32'h3000_0000, 32'h300, 1'b0, 1'b1);    // start pulsed mid-job
    reset_mid_job();
    run_job(32'h6000_0000, 32'h180, 1'b0, 1'b0);    // normal job after reset
    run_job(32'hFFFF_FF80, 32'h180, 1'b0, 1'b0);    // address wraps past 2^32

    for (int j = 0; j < 20; j++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      if (r == 0)      l = 32'd0;
      else if (r == 1) l = (32'($urandom_range(0, 64)) << 2) | 32'($urandom_range(1, 3));
      else             l = 32'($urandom_range(1, 320)) << 2;
      run_job(a, l, 1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
